time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning clk cycles per 1 Hz tick (min 2).
REQ-002 SHALL have parameter TIMEOUT_S, default 10, meaning idle seconds in an edit state before abort (min 1).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports btn_mode, btn_up, btn_down  input  1 each  debounced, synchronized button levels.
REQ-006 SHALL have ports cur_sec  input  6, cur_min  input  6, cur_hour  input  5  running time from the timekeeper.
REQ-007 SHALL have port tick  output  1  one-cycle advance pulse to the timekeeper.
REQ-008 SHALL have port set  output  1  one-cycle load strobe to the timekeeper.
REQ-009 SHALL have ports sec_set  output  6, min_set  output  6, hour_set  output  5  value presented with set.
REQ-010 SHALL have port mode  output  2  0=RUN, 1=hour, 2=min, 3=sec field under edit.

Function
REQ-011 SHALL implement states RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
REQ-012 Press SHALL mean a rising edge: button high this cycle, low the previous cycle.
REQ-013 RUN + mode press SHALL capture cur_hour/min/sec into hour_set/min_set/sec_set and enter EDIT_HOUR next cycle.
REQ-014 Mode press SHALL step EDIT_HOUR->EDIT_MIN->EDIT_SEC->COMMIT.
REQ-015 COMMIT SHALL last exactly one cycle, assert set with the edit registers stable, then return to RUN.
REQ-016 Up press in an edit state SHALL increment the selected field: hour 23->0, min/sec 59->0.
REQ-017 Down press SHALL decrement: hour 0->23, min/sec 0->59.
REQ-018 Up and down pressed the same cycle SHALL leave the field unchanged.
REQ-019 Mode pressed the same cycle as up/down SHALL take priority; no field change that cycle.
REQ-020 Up/down presses in RUN or COMMIT SHALL be ignored.
REQ-021 Divider SHALL count 0..CLK_HZ-1 and wrap; the cycle with count CLK_HZ-1 is a second boundary.
REQ-022 tick SHALL pulse at each second boundary only in RUN; edit states and COMMIT suppress it.
REQ-023 Divider SHALL clear to 0 in COMMIT; first tick after set comes exactly CLK_HZ cycles after the set cycle.
REQ-024 Idle counter SHALL clear on entry to an edit state and on any mode/up/down press, and increment at each second boundary.
REQ-025 Idle counter reaching TIMEOUT_S SHALL return to RUN next cycle without set; the timekeeper keeps its time.
REQ-026 sec_set/min_set/hour_set SHALL always hold in-range values (sec/min <=59, hour <=23).
REQ-027 mode SHALL be 0 in RUN and COMMIT.
REQ-028 set and tick SHALL never assert in the same cycle.

Reset
REQ-029 reset low at a clk edge SHALL force: state RUN, divider 0, idle counter 0, tick 0, set 0, mode 0, all *_set 0.
REQ-030 During reset the previous-button registers SHALL load the current button levels, so a button held through reset release yields no press.
REQ-031 reset low mid-edit SHALL abandon the edit with no set pulse.

Structure
REQ-032 A shared package clock_pkg SHALL hold the state enum, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, and the field widths 6/6/5.
REQ-033 The 1 Hz divider SHALL be a sub-module tick_div (clk, reset, clr, boundary), parameterized by CLK_HZ.
REQ-034 Field wrap arithmetic SHALL compare before add/subtract; no reliance on modulo or overflow of the field width.

Verification (CLK_HZ=10, TIMEOUT_S=3)
REQ-035 Reset released, idle 35 cycles -> tick at cycles 9, 19, 29; set never asserts.
REQ-036 cur=23:59:58, mode press, up on hour, mode, down on min, mode, up on sec, mode -> one set pulse with hour_set=0, min_set=58, sec_set=59; next tick 10 cycles later.
REQ-037 In EDIT_MIN at min=0: down -> 59; up -> 0; up+down same cycle -> 0 unchanged.
REQ-038 Enter EDIT_HOUR, no presses -> back to RUN after 3 second boundaries, set never asserts, no tick while editing.
REQ-039 mode+up in same cycle in EDIT_HOUR -> state EDIT_MIN, hour_set unchanged.
REQ-040 btn_mode held high across reset release -> remains RUN; reset pulsed in EDIT_SEC -> RUN, all outputs 0, no set.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting controller.
//   state_e          : controller states
//   SEC_W/MIN_W/HOUR_W : field widths of the time value
//   SEC_MAX/MIN_MAX/HOUR_MAX : largest legal field value
//   inc*/dec*        : wrap-around step helpers; the limit is compared before
//                      the add/subtract, so nothing depends on field overflow
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_EDIT_HOUR = 3'd1,
    ST_EDIT_MIN  = 3'd2,
    ST_EDIT_SEC  = 3'd3,
    ST_COMMIT    = 3'd4
  } state_e;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  function automatic logic [5:0] inc6(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec6(input logic [5:0] v, input logic [5:0] max_v);
    return ((v == 6'd0) || (v > max_v)) ? max_v : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc5(input logic [4:0] v, input logic [4:0] max_v);
    return (v >= max_v) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec5(input logic [4:0] v, input logic [4:0] max_v);
    return ((v == 5'd0) || (v > max_v)) ? max_v : v - 5'd1;
  endfunction

endpackage

// File: rtl/tick_div.sv
// 1 Hz divider: counts 0..CLK_HZ-1 and wraps.
//   clk      : clock
//   reset    : synchronous active-low reset (count to 0)
//   clr      : synchronous clear (count to 0 next cycle)
//   boundary : high during the cycle whose count is CLK_HZ-1
module tick_div #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic boundary
);

  localparam int                CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign boundary = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || boundary) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time setting for a clock timekeeper.
// In RUN it forwards 1 Hz ticks; a mode press snapshots the running time and
// walks hour -> min -> sec edit, then a one-cycle COMMIT loads the edited value.
// An edit left untouched for TIMEOUT_S seconds is abandoned without a load.
//   clk, reset                  : clock, synchronous active-low reset
//   btn_mode/btn_up/btn_down    : debounced button levels (press = rising edge)
//   cur_sec/cur_min/cur_hour    : running time from the timekeeper
//   tick                        : 1 Hz advance pulse (RUN only)
//   set                         : load strobe, with sec_set/min_set/hour_set
//   mode                        : 0 run/commit, 1 hour, 2 min, 3 sec under edit
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_RUN       | time runs, ticks forwarded, up/down ignored
// ST_EDIT_HOUR | hour field adjustable
// ST_EDIT_MIN  | minute field adjustable
// ST_EDIT_SEC  | second field adjustable
// ST_COMMIT    | one cycle: set asserted, divider restarted
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] cur_hour,
  output logic              tick,
  output logic              set,
  output logic [SEC_W-1:0]  sec_set,
  output logic [MIN_W-1:0]  min_set,
  output logic [HOUR_W-1:0] hour_set,
  output logic [1:0]        mode
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_S + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_S);

  state_e              state_q, state_d;
  logic                btn_mode_q, btn_up_q, btn_down_q;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [MIN_W-1:0]    min_q, min_d;
  logic [HOUR_W-1:0]   hour_q, hour_d;

  logic press_mode, press_up, press_down;
  logic adj_up, adj_dn;
  logic boundary, div_clr;

  assign press_mode = btn_mode & ~btn_mode_q;
  assign press_up   = btn_up   & ~btn_up_q;
  assign press_down = btn_down & ~btn_down_q;

  // Simultaneous up and down cancel out.
  assign adj_up = press_up & ~press_down;
  assign adj_dn = press_down & ~press_up;

  // Restarting the divider on commit puts the first tick CLK_HZ cycles after set.
  assign div_clr = (state_q == ST_COMMIT);

  tick_div #(.CLK_HZ(CLK_HZ)) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .clr      (div_clr),
    .boundary (boundary)
  );

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    unique case (state_q)
      ST_RUN: begin
        idle_d = '0;
        if (press_mode) begin
          // Clamp keeps the edit registers legal even if the timekeeper is not.
          hour_d  = (cur_hour > HOUR_MAX) ? HOUR_MAX : cur_hour;
          min_d   = (cur_min  > MIN_MAX)  ? MIN_MAX  : cur_min;
          sec_d   = (cur_sec  > SEC_MAX)  ? SEC_MAX  : cur_sec;
          state_d = ST_EDIT_HOUR;
        end
      end
      ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC: begin
        if (idle_q >= IDLE_LIMIT) begin
          state_d = ST_RUN;
          idle_d  = '0;
        end else if (press_mode) begin
          idle_d = '0;
          if (state_q == ST_EDIT_HOUR)     state_d = ST_EDIT_MIN;
          else if (state_q == ST_EDIT_MIN) state_d = ST_EDIT_SEC;
          else                             state_d = ST_COMMIT;
        end else begin
          if (press_up || press_down) begin
            idle_d = '0;
          end else if (boundary) begin
            idle_d = idle_q + IDLE_W'(1);
          end
          if (state_q == ST_EDIT_HOUR) begin
            if (adj_up)      hour_d = inc5(hour_q, HOUR_MAX);
            else if (adj_dn) hour_d = dec5(hour_q, HOUR_MAX);
          end else if (state_q == ST_EDIT_MIN) begin
            if (adj_up)      min_d = inc6(min_q, MIN_MAX);
            else if (adj_dn) min_d = dec6(min_q, MIN_MAX);
          end else begin
            if (adj_up)      sec_d = inc6(sec_q, SEC_MAX);
            else if (adj_dn) sec_d = dec6(sec_q, SEC_MAX);
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_RUN;
        idle_d  = '0;
      end
      default: begin
        state_d = ST_RUN;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      idle_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      // Track live levels so a button held through reset release is not a press.
      btn_mode_q <= btn_mode;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      btn_mode_q <= btn_mode;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
    end
  end

  assign tick     = boundary && (state_q == ST_RUN);
  assign set      = (state_q == ST_COMMIT);
  assign sec_set  = sec_q;
  assign min_set  = min_q;
  assign hour_set = hour_q;

  always_comb begin
    mode = 2'd0;
    unique case (state_q)
      ST_EDIT_HOUR: mode = 2'd1;
      ST_EDIT_MIN:  mode = 2'd2;
      ST_EDIT_SEC:  mode = 2'd3;
      default:      mode = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int TIMEOUT_S = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic [5:0] cur_sec, cur_min;
  logic [4:0] cur_hour;
  logic       tick, set;
  logic [5:0] sec_set, min_set;
  logic [4:0] hour_set;
  logic [1:0] mode;

  always #5 clk = ~clk;

  time_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .cur_sec  (cur_sec),
    .cur_min  (cur_min),
    .cur_hour (cur_hour),
    .tick     (tick),
    .set      (set),
    .sec_set  (sec_set),
    .min_set  (min_set),
    .hour_set (hour_set),
    .mode     (mode)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: st 0=run 1=hour 2=min 3=sec 4=commit; time in plain ints.
  int   m_st, m_div, m_idle, m_h, m_m, m_s;
  logic m_pm, m_pu, m_pd;

  typedef struct {
    logic m, u, d;
    int   emode, eset, eh, emin, esec;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_tick", tick, (m_st == 0 && m_div == CLK_HZ - 1) ? 1 : 0);
    chk("m_set", set, (m_st == 4) ? 1 : 0);
    chk("m_mode", mode, (m_st >= 1 && m_st <= 3) ? m_st : 0);
    chk("m_hour", hour_set, m_h);
    chk("m_min", min_set, m_m);
    chk("m_sec", sec_set, m_s);
    chk("m_tick_set_excl", tick && set, 0);
  endtask

  task automatic model_update();
    bit mp, up, dn, bnd;
    int nst, nidle, delta;
    if (!reset) begin
      m_st = 0; m_div = 0; m_idle = 0; m_h = 0; m_m = 0; m_s = 0;
      m_pm = btn_mode; m_pu = btn_up; m_pd = btn_down;
      return;
    end
    mp  = btn_mode && !m_pm;
    up  = btn_up && !m_pu;
    dn  = btn_down && !m_pd;
    bnd = (m_div == CLK_HZ - 1);
    nst = m_st;
    nidle = m_idle;
    case (m_st)
      0: begin
        nidle = 0;
        if (mp) begin
          m_h = (cur_hour > 23) ? 23 : cur_hour;
          m_m = (cur_min > 59) ? 59 : cur_min;
          m_s = (cur_sec > 59) ? 59 : cur_sec;
          nst = 1;
        end
      end
      4: begin nst = 0; nidle = 0; end
      default: begin
        if (m_idle >= TIMEOUT_S) begin nst = 0; nidle = 0; end
        else if (mp) begin nst = m_st + 1; nidle = 0; end
        else begin
          if (up || dn) nidle = 0;
          else if (bnd) nidle = m_idle + 1;
          if (up != dn) begin
            delta = up ? 1 : -1;
            case (m_st)
              1: m_h = (m_h + delta + 24) % 24;
              2: m_m = (m_m + delta + 60) % 60;
              default: m_s = (m_s + delta + 60) % 60;
            endcase
          end
        end
      end
    endcase
    m_div  = (m_st == 4) ? 0 : (m_div + 1) % CLK_HZ;
    m_st   = nst;
    m_idle = nidle;
    m_pm = btn_mode; m_pu = btn_up; m_pd = btn_down;
  endtask

  // One clock: check the model at the current falling edge, drive, advance.
  task automatic cycle(input logic m, input logic u, input logic d);
    model_check();
    btn_mode = m; btn_up = u; btn_down = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    cycle(m, u, d);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks[$];
    int nset, found, n, nt, ns;
    bit quiet;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 10, 0, 30};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1, 0, 10, 0, 30};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2, 0, 10, 0, 30};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2, 0, 10, 0, 30};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2, 0, 10, 59, 30};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2, 0, 10, 59, 30};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2, 0, 10, 0, 30};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2, 0, 10, 0, 30};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2, 0, 10, 0, 30};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2, 0, 10, 0, 30};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3, 0, 10, 0, 30};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3, 0, 10, 0, 30};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 3, 0, 10, 0, 29};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 3, 0, 10, 0, 29};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 0, 1, 10, 0, 29};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 0, 0, 10, 0, 29};

    reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cur_sec = '0; cur_min = '0; cur_hour = '0;
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);

    chk("rst_tick", tick, 0);
    chk("rst_set", set, 0);
    chk("rst_mode", mode, 0);
    chk("rst_hour", hour_set, 0);
    chk("rst_min", min_set, 0);
    chk("rst_sec", sec_set, 0);

    // Free-running ticks after reset release.
    reset = 1'b1;
    nset = 0;
    for (int i = 0; i < 35; i++) begin
      if (tick) ticks.push_back(i);
      if (set) nset++;
      cycle(1'b0, 1'b0, 1'b0);
    end
    chk("idle_tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      for (int k = 0; k < 3; k++) chk($sformatf("idle_tick%0d_cycle", k), ticks[k], 9 + 10 * k);
    end
    chk("idle_no_set", nset, 0);

    // Vector table: field wrap at min=0, cancel, mode priority, commit.
    cur_hour = 5'd10; cur_min = 6'd0; cur_sec = 6'd30;
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].m, vecs[i].u, vecs[i].d);
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].emode);
      chk($sformatf("vec%0d_set", i), set, vecs[i].eset);
      chk($sformatf("vec%0d_hour", i), hour_set, vecs[i].eh);
      chk($sformatf("vec%0d_min", i), min_set, vecs[i].emin);
      chk($sformatf("vec%0d_sec", i), sec_set, vecs[i].esec);
    end

    // Full edit from 23:59:58 with wraps, then tick latency after set.
    cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd58;
    press(1'b1, 1'b0, 1'b0);
    chk("full_capture_h", hour_set, 23);
    chk("full_capture_m", min_set, 59);
    chk("full_capture_s", sec_set, 58);
    press(1'b0, 1'b1, 1'b0);
    chk("full_hour_wrap", hour_set, 0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    chk("full_min_dec", min_set, 58);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("full_sec_inc", sec_set, 59);
    cycle(1'b1, 1'b0, 1'b0);
    chk("full_set", set, 1);
    chk("full_set_h", hour_set, 0);
    chk("full_set_m", min_set, 58);
    chk("full_set_s", sec_set, 59);
    found = -1; nset = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (tick && found < 0) found = k;
      if (set) nset++;
    end
    chk("full_tick_latency", found, 10);
    chk("full_single_set", nset, 0);

    // Abandon by inactivity.
    cycle(1'b1, 1'b0, 1'b0);
    chk("to_enter", mode, 1);
    n = 0; nt = 0; ns = 0;
    while (mode != 2'd0 && n < 60) begin
      if (tick) nt++;
      if (set) ns++;
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("to_back_run", mode, 0);
    chk("to_window", (n >= 22 && n <= 31) ? 1 : 0, 1);
    chk("to_no_tick", nt, 0);
    chk("to_no_set", ns, 0);
    chk("to_no_set_after", set, 0);

    // Mode held across reset release, then reset mid-edit.
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    chk("held_stays_run", mode, 0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    chk("rst_edit_sec", mode, 3);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    chk("rst_mid_mode", mode, 0);
    chk("rst_mid_set", set, 0);
    chk("rst_mid_tick", tick, 0);
    chk("rst_mid_hour", hour_set, 0);
    chk("rst_mid_min", min_set, 0);
    chk("rst_mid_sec", sec_set, 0);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    chk("rst_mid_no_set", set, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 400) % 2) == 1;
      reset = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
        cur_sec  = 6'($urandom_range(0, 59));
      end
      if (quiet)
        cycle($urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0);
      else
        cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
